// File: rtl/p2_pkg.sv
// Shared types for the P2 multiply/divide/root datapath: operation codes and
// the result unloader state encoding.
package p2_pkg;

  // Operation code captured alongside the MDR result. RSVD behaves as MUL.
  typedef enum logic [1:0] {
    MUL  = 2'b00,
    DIV  = 2'b01,
    SQRT = 2'b10,
    RSVD = 2'b11
  } op_t;

  // Result unloader sequencing states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    SHOW_RES = 3'd2,
    SHOW_REM = 3'd3,
    SHOW_ERR = 3'd4,
    RELEASE  = 3'd5
  } unload_state_t;

  // Only DIV and SQRT produce a remainder word worth presenting.
  function automatic logic op_has_remainder(input op_t op);
    return (op == DIV) || (op == SQRT);
  endfunction

endpackage

// File: rtl/result_unloader_if.sv
// Bus between the MDR/Error modules, the user controls and the board outputs
// for the result unloader. The slave side is the unloader itself.
// The one-cycle release pulse is named release_pulse because "release" is a
// reserved word.
interface result_unloader_if #(
  parameter int unsigned WORD_LENGTH = 16
);

  // MDR / Error module side
  logic                   ready;
  logic [WORD_LENGTH-1:0] result;
  logic [WORD_LENGTH-1:0] remainder;
  logic                   sign;
  logic                   error;
  logic [1:0]             op;

  // User request
  logic                   unload;

  // Presented outputs
  logic [WORD_LENGTH-1:0] data_out;
  logic                   sign_out;
  logic                   showResult;
  logic                   showRemainder;
  logic                   error_out;
  logic                   busy;
  logic                   release_pulse;
  logic                   overrun;

  modport slave (
    input  ready, result, remainder, sign, error, op, unload,
    output data_out, sign_out, showResult, showRemainder, error_out,
           busy, release_pulse, overrun
  );

  modport master (
    output ready, result, remainder, sign, error, op, unload,
    input  data_out, sign_out, showResult, showRemainder, error_out,
           busy, release_pulse, overrun
  );

endinterface

// File: rtl/edge_detector.sv
// Rising-edge detector: one delay register, rise is high for the cycle in
// which the input is high and was low at the previous clock edge.
module edge_detector (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_d;

  // Delay register; clears on reset so an input already high counts as a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_d <= 1'b0;
    end else begin
      in_d <= in;
    end
  end

  assign rise = in & ~in_d;

endmodule

// File: rtl/result_unloader.sv
// Result unloader: snapshots the MDR outputs on a ready rise and presents
// result, then remainder (DIV/SQRT) or an error word, one word per unload
// rise, followed by a one-cycle release pulse.
module result_unloader
  import p2_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 16
) (
  input logic              clk,
  input logic              reset,
  result_unloader_if.slave bus
);

  logic ready_rise;
  logic unload_rise;

  edge_detector u_ready_edge (
    .clk   (clk),
    .reset (reset),
    .in    (bus.ready),
    .rise  (ready_rise)
  );

  edge_detector u_unload_edge (
    .clk   (clk),
    .reset (reset),
    .in    (bus.unload),
    .rise  (unload_rise)
  );

  unload_state_t          state;
  logic [WORD_LENGTH-1:0] result_q;
  logic [WORD_LENGTH-1:0] remainder_q;
  logic                   sign_q;
  logic                   error_q;
  op_t                    op_q;

  logic in_busy_state;
  logic capture;

  // Capture is only accepted when no snapshot is held (IDLE or RELEASE).
  always_comb begin
    in_busy_state = 1'b0;
    capture       = 1'b0;
    in_busy_state = (state == ARMED) || (state == SHOW_RES) ||
                    (state == SHOW_REM) || (state == SHOW_ERR);
    capture       = ready_rise && ((state == IDLE) || (state == RELEASE));
  end

  // Sequencer with snapshot, overrun tracking and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      result_q          <= '0;
      remainder_q       <= '0;
      sign_q            <= 1'b0;
      error_q           <= 1'b0;
      op_q              <= MUL;
      bus.data_out      <= '0;
      bus.sign_out      <= 1'b0;
      bus.showResult    <= 1'b0;
      bus.showRemainder <= 1'b0;
      bus.error_out     <= 1'b0;
      bus.busy          <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.overrun       <= 1'b0;
    end else begin
      bus.release_pulse <= 1'b0;

      if (capture) begin
        result_q    <= bus.result;
        remainder_q <= bus.remainder;
        sign_q      <= bus.sign;
        error_q     <= bus.error;
        op_q        <= op_t'(bus.op);
        bus.overrun <= 1'b0;
      end else if (ready_rise && in_busy_state) begin
        bus.overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (capture) begin
            state    <= ARMED;
            bus.busy <= 1'b1;
          end
        end

        ARMED: begin
          if (unload_rise) begin
            if (error_q) begin
              state         <= SHOW_ERR;
              bus.data_out  <= '1;
              bus.error_out <= 1'b1;
            end else begin
              state          <= SHOW_RES;
              bus.data_out   <= result_q;
              bus.showResult <= 1'b1;
              bus.sign_out   <= sign_q;
            end
          end
        end

        SHOW_RES: begin
          if (unload_rise) begin
            bus.showResult <= 1'b0;
            bus.sign_out   <= 1'b0;
            if (op_has_remainder(op_q)) begin
              state             <= SHOW_REM;
              bus.data_out      <= remainder_q;
              bus.showRemainder <= 1'b1;
            end else begin
              state             <= RELEASE;
              bus.data_out      <= '0;
              bus.busy          <= 1'b0;
              bus.release_pulse <= 1'b1;
            end
          end
        end

        SHOW_REM: begin
          if (unload_rise) begin
            state             <= RELEASE;
            bus.data_out      <= '0;
            bus.showRemainder <= 1'b0;
            bus.busy          <= 1'b0;
            bus.release_pulse <= 1'b1;
          end
        end

        SHOW_ERR: begin
          if (unload_rise) begin
            state             <= RELEASE;
            bus.data_out      <= '0;
            bus.error_out     <= 1'b0;
            bus.busy          <= 1'b0;
            bus.release_pulse <= 1'b1;
          end
        end

        RELEASE: begin
          if (capture) begin
            state    <= ARMED;
            bus.busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state             <= IDLE;
          bus.data_out      <= '0;
          bus.sign_out      <= 1'b0;
          bus.showResult    <= 1'b0;
          bus.showRemainder <= 1'b0;
          bus.error_out     <= 1'b0;
          bus.busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_unloader.sv
// Directed bench for result_unloader: a vector table walks DIV, MUL, error,
// overrun, back-to-back capture and reserved-op sequences; hand-written
// sequences cover held unload and asynchronous reset mid-operation.
module tb_result_unloader;

  logic clk;
  logic reset;

  result_unloader_if #(.WORD_LENGTH(16)) bus ();

  result_unloader #(.WORD_LENGTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        unl;
    logic [15:0] res;
    logic [15:0] rem;
    logic        sgn;
    logic        err;
    logic [1:0]  op;
    logic [15:0] e_data;
    logic        e_sg;
    logic        e_sr;
    logic        e_rm;
    logic        e_er;
    logic        e_bz;
    logic        e_rl;
    logic        e_ov;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic rdy, input logic unl, input logic [15:0] res,
                     input logic [15:0] rem, input logic sgn, input logic err,
                     input logic [1:0] op, input logic [15:0] d, input logic sg,
                     input logic sr, input logic rm, input logic er,
                     input logic bz, input logic rl, input logic ov);
    vec_t v;
    v = '{rdy, unl, res, rem, sgn, err, op, d, sg, sr, rm, er, bz, rl, ov};
    vecs.push_back(v);
  endtask

  function automatic logic [22:0] pack(input logic [15:0] d, input logic sg,
                                       input logic sr, input logic rm,
                                       input logic er, input logic bz,
                                       input logic rl, input logic ov);
    return {d, sg, sr, rm, er, bz, rl, ov};
  endfunction

  // Packed layout: data[22:7] sign_out showResult showRemainder error_out busy release overrun
  task automatic check(input string nm, input logic [22:0] exp_v);
    logic [22:0] act;
    act = {bus.data_out, bus.sign_out, bus.showResult, bus.showRemainder,
           bus.error_out, bus.busy, bus.release_pulse, bus.overrun};
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got data=%h flags=%b, expected data=%h flags=%b",
               nm, act[22:7], act[6:0], exp_v[22:7], exp_v[6:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic unl, input logic [15:0] res,
                       input logic [15:0] rem, input logic sgn, input logic err,
                       input logic [1:0] op);
    bus.ready     = rdy;
    bus.unload    = unl;
    bus.result    = res;
    bus.remainder = rem;
    bus.sign      = sgn;
    bus.error     = err;
    bus.op        = op;
  endtask

  initial begin
    // DIV 7 r 3
    add(1,0,16'h0007,16'h0003,0,0,2'd1, 16'h0000,0,0,0,0,1,0,0);
    add(1,1,16'h0007,16'h0003,0,0,2'd1, 16'h0007,0,1,0,0,1,0,0);
    add(0,0,16'h0007,16'h0003,0,0,2'd1, 16'h0007,0,1,0,0,1,0,0);
    add(0,1,16'h0007,16'h0003,0,0,2'd1, 16'h0003,0,0,1,0,1,0,0);
    add(0,0,16'h0007,16'h0003,0,0,2'd1, 16'h0003,0,0,1,0,1,0,0);
    add(0,1,16'h0007,16'h0003,0,0,2'd1, 16'h0000,0,0,0,0,0,1,0);
    add(0,0,16'h0007,16'h0003,0,0,2'd1, 16'h0000,0,0,0,0,0,0,0);
    add(0,1,16'h0007,16'h0003,0,0,2'd1, 16'h0000,0,0,0,0,0,0,0);
    add(0,0,16'h0007,16'h0003,0,0,2'd1, 16'h0000,0,0,0,0,0,0,0);
    // MUL 0xC8, sign 1
    add(1,0,16'h00C8,16'h5555,1,0,2'd0, 16'h0000,0,0,0,0,1,0,0);
    add(1,1,16'h00C8,16'h5555,1,0,2'd0, 16'h00C8,1,1,0,0,1,0,0);
    add(0,0,16'h00C8,16'h5555,1,0,2'd0, 16'h00C8,1,1,0,0,1,0,0);
    add(0,1,16'h00C8,16'h5555,1,0,2'd0, 16'h0000,0,0,0,0,0,1,0);
    add(0,0,16'h00C8,16'h5555,1,0,2'd0, 16'h0000,0,0,0,0,0,0,0);
    // error with DIV; error input drops after capture
    add(1,0,16'h1111,16'h2222,1,1,2'd1, 16'h0000,0,0,0,0,1,0,0);
    add(0,1,16'h1111,16'h2222,1,0,2'd1, 16'hFFFF,0,0,0,1,1,0,0);
    add(0,0,16'h1111,16'h2222,1,0,2'd1, 16'hFFFF,0,0,0,1,1,0,0);
    add(0,1,16'h1111,16'h2222,1,0,2'd1, 16'h0000,0,0,0,0,0,1,0);
    add(0,0,16'h1111,16'h2222,1,0,2'd1, 16'h0000,0,0,0,0,0,0,0);
    // overrun while showing result
    add(1,0,16'h0AAA,16'h0005,0,0,2'd1, 16'h0000,0,0,0,0,1,0,0);
    add(0,1,16'h0AAA,16'h0005,0,0,2'd1, 16'h0AAA,0,1,0,0,1,0,0);
    add(1,0,16'h1234,16'h0009,0,0,2'd0, 16'h0AAA,0,1,0,0,1,0,1);
    add(0,0,16'h1234,16'h0009,0,0,2'd0, 16'h0AAA,0,1,0,0,1,0,1);
    add(0,1,16'h1234,16'h0009,0,0,2'd0, 16'h0005,0,0,1,0,1,0,1);
    add(0,0,16'h1234,16'h0009,0,0,2'd0, 16'h0005,0,0,1,0,1,0,1);
    add(0,1,16'h1234,16'h0009,0,0,2'd0, 16'h0000,0,0,0,0,0,1,1);
    add(0,0,16'h1234,16'h0009,0,0,2'd0, 16'h0000,0,0,0,0,0,0,1);
    add(1,0,16'h1234,16'h0009,0,0,2'd0, 16'h0000,0,0,0,0,1,0,0);
    add(0,1,16'h1234,16'h0009,0,0,2'd0, 16'h1234,0,1,0,0,1,0,0);
    add(0,0,16'h1234,16'h0009,0,0,2'd0, 16'h1234,0,1,0,0,1,0,0);
    add(0,1,16'h1234,16'h0009,0,0,2'd0, 16'h0000,0,0,0,0,0,1,0);
    // capture during the RELEASE cycle goes straight to ARMED (SQRT)
    add(1,0,16'h00AB,16'h0002,1,0,2'd2, 16'h0000,0,0,0,0,1,0,0);
    add(0,1,16'h00AB,16'h0002,1,0,2'd2, 16'h00AB,1,1,0,0,1,0,0);
    add(0,0,16'h00AB,16'h0002,1,0,2'd2, 16'h00AB,1,1,0,0,1,0,0);
    add(0,1,16'h00AB,16'h0002,1,0,2'd2, 16'h0002,0,0,1,0,1,0,0);
    add(0,0,16'h00AB,16'h0002,1,0,2'd2, 16'h0002,0,0,1,0,1,0,0);
    add(0,1,16'h00AB,16'h0002,1,0,2'd2, 16'h0000,0,0,0,0,0,1,0);
    add(0,0,16'h00AB,16'h0002,1,0,2'd2, 16'h0000,0,0,0,0,0,0,0);
    // reserved op behaves as MUL: no remainder word
    add(1,0,16'h0042,16'h7777,0,0,2'd3, 16'h0000,0,0,0,0,1,0,0);
    add(0,1,16'h0042,16'h7777,0,0,2'd3, 16'h0042,0,1,0,0,1,0,0);
    add(0,0,16'h0042,16'h7777,0,0,2'd3, 16'h0042,0,1,0,0,1,0,0);
    add(0,1,16'h0042,16'h7777,0,0,2'd3, 16'h0000,0,0,0,0,0,1,0);
    add(0,0,16'h0042,16'h7777,0,0,2'd3, 16'h0000,0,0,0,0,0,0,0);

    // Reset state
    reset = 1'b1;
    drive(0,0,16'h0,16'h0,0,0,2'd0);
    tick();
    tick();
    check("reset_state", pack(16'h0,0,0,0,0,0,0,0));
    reset = 1'b0;
    tick();
    check("idle_after_reset", pack(16'h0,0,0,0,0,0,0,0));

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rdy, vecs[i].unl, vecs[i].res, vecs[i].rem,
            vecs[i].sgn, vecs[i].err, vecs[i].op);
      tick();
      check($sformatf("vec%0d", i),
            pack(vecs[i].e_data, vecs[i].e_sg, vecs[i].e_sr, vecs[i].e_rm,
                 vecs[i].e_er, vecs[i].e_bz, vecs[i].e_rl, vecs[i].e_ov));
    end

    // Held unload in ARMED advances exactly once
    drive(1,0,16'h0BEE,16'h0001,0,0,2'd1);
    tick();
    check("held_armed", pack(16'h0,0,0,0,0,1,0,0));
    drive(0,1,16'h0BEE,16'h0001,0,0,2'd1);
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("held_unload_c%0d", c), pack(16'h0BEE,0,1,0,0,1,0,0));
    end
    bus.unload = 1'b0;
    tick();
    check("held_released", pack(16'h0BEE,0,1,0,0,1,0,0));
    bus.unload = 1'b1;
    tick();
    check("held_to_rem", pack(16'h0001,0,0,1,0,1,0,0));
    bus.unload = 1'b0;
    tick();
    check("rem_steady", pack(16'h0001,0,0,1,0,1,0,0));

    // Asynchronous reset in SHOW_REM, ready already high when it lifts
    reset = 1'b1;
    #1;
    check("async_reset", pack(16'h0,0,0,0,0,0,0,0));
    drive(1,0,16'h0321,16'h0000,0,0,2'd0);
    tick();
    check("in_reset_1", pack(16'h0,0,0,0,0,0,0,0));
    tick();
    check("in_reset_2", pack(16'h0,0,0,0,0,0,0,0));
    reset = 1'b0;
    tick();
    check("capture_after_reset", pack(16'h0,0,0,0,0,1,0,0));
    drive(0,1,16'h0321,16'h0000,0,0,2'd0);
    tick();
    check("result_after_reset", pack(16'h0321,0,1,0,0,1,0,0));
    bus.unload = 1'b0;
    tick();
    bus.unload = 1'b1;
    tick();
    check("release_after_reset", pack(16'h0,0,0,0,0,0,1,0));
    bus.unload = 1'b0;
    tick();
    check("idle_final", pack(16'h0,0,0,0,0,0,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/result_unloader.md
# result_unloader

Output-side counterpart to the operand loader of the P2 multiply/divide/root datapath. It snapshots the MDR outputs when `ready` rises and presents them one word at a time on a shared output bus under user `unload` requests: the result first, then the remainder when the operation produces one, or an error word. After the last word it pulses `release`, which tells upstream that a new operation may start. It sits between the MDR/Error modules and the board outputs, mirroring how the loader steps X then Y in on `load`.

## Interface
Parameters:
- WORD_LENGTH, 16, width of the data words

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ready  in  1  MDR completion level; a rising edge triggers capture
- result  in  WORD_LENGTH  MDR quotient, product or root
- remainder  in  WORD_LENGTH  MDR remainder
- sign  in  1  MDR result sign
- error  in  1  Error module flag
- op  in  2  operation code, sampled at capture
- unload  in  1  user request; rising edge advances one word; may be held
- data_out  out  WORD_LENGTH  currently presented word
- sign_out  out  1  captured sign, valid while showResult=1
- showResult  out  1  data_out holds the result
- showRemainder  out  1  data_out holds the remainder
- error_out  out  1  data_out holds the error word
- busy  out  1  a snapshot is held and not yet fully unloaded
- release  out  1  one-cycle pulse after the last word is consumed
- overrun  out  1  sticky; a `ready` edge arrived while busy

## Operation
- Op encoding: 00 MUL, 01 DIV, 10 SQRT, 11 reserved (treated as MUL).
- Remainder word is presented for DIV and SQRT only.
- Rising edges are detected with one delay register per input. Delay registers reset to 0.
- States: IDLE, ARMED, SHOW_RES, SHOW_REM, SHOW_ERR, RELEASE.
- IDLE: on a `ready` rise, load result_q, remainder_q, sign_q, error_q and op_q, clear overrun, go to ARMED. `unload` edges are ignored.
- ARMED: on an `unload` rise, go to SHOW_ERR if error_q, else go to SHOW_RES.
- SHOW_RES: data_out=result_q, showResult=1, sign_out=sign_q. On an `unload` rise, go to SHOW_REM if op_q is DIV or SQRT, else go to RELEASE.
- SHOW_REM: data_out=remainder_q, showRemainder=1. On an `unload` rise, go to RELEASE.
- SHOW_ERR: data_out is all ones, error_out=1. On an `unload` rise, go to RELEASE.
- RELEASE: release=1 for exactly one cycle. A `ready` rise in this cycle performs a capture and goes directly to ARMED; otherwise go to IDLE.
- busy=1 in ARMED, SHOW_RES, SHOW_REM and SHOW_ERR.
- A `ready` rise while busy does not disturb the snapshot and sets overrun. Overrun stays set until the next capture.
- In IDLE, ARMED and RELEASE, data_out=0 and all show flags are 0.
- Snapshot values are never modified except by a capture.

## Timing
- Reset: state IDLE, all outputs 0, snapshot registers 0, delay registers 0.
- Reset mid-operation aborts immediately: no release pulse, snapshot lost.
- Capture latency: ready is high at edge N with ready_d=0, so registers load at edge N and busy=1 after edge N.
- A `ready` already high on the first edge after reset counts as a rise.
- Each `unload` rise at edge N: the new word and flags are visible after edge N (registered outputs, no combinational input-to-output path).
- A held `unload` advances exactly once. At least one low cycle is required between requests.
- Minimum cycle from capture to release for MUL: capture, then 2 unload rises, then 1 RELEASE cycle.

## Structure
- p2_pkg holds the op_t enum (MUL/DIV/SQRT/RSVD) and the unload_state_t enum, shared with the loader and MDR.
- One sub-module, `edge_detector` (clk, reset, in, rise), instantiated for `ready` and `unload`.

## Test plan
- DIV with result=0x0007, remainder=0x0003, sign=0: ready rise then 3 unload pulses -> data_out 0x0007 with showResult, then 0x0003 with showRemainder, then a release pulse of 1 cycle, then IDLE with data_out 0.
- MUL with result=0x00C8, sign=1: 2 unload pulses -> 0x00C8 with showResult and sign_out=1, then release; showRemainder never asserts.
- error=1 with op=DIV: 2 unload pulses -> 0xFFFF with error_out, then release; showResult never asserts.
- Second ready rise while in SHOW_RES with new result=0x1234 -> overrun=1 and data_out stays at the old value; overrun clears on the next capture after release.
- unload held high for 10 cycles in ARMED -> exactly one advance to SHOW_RES; unload pulses while in IDLE -> no change.
- reset asserted in SHOW_REM -> all outputs 0 asynchronously, no release pulse; a new ready rise then captures normally.
